// File: rtl/f_multdiv_seq_if.sv
// Handshake and result bundle between the control unit and the MULT/DIV sequencer.
interface f_multdiv_seq_if;
  logic        start_mult;
  logic        start_div;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  modport master (
    output start_mult, start_div, op_a, op_b,
    input  busy, done, div_zero, hi_out, lo_out
  );

  modport slave (
    input  start_mult, start_div, op_a, op_b,
    output busy, done, div_zero, hi_out, lo_out
  );
endinterface

// File: rtl/f_multdiv_seq.sv
// Multicycle signed Booth multiply / restoring divide sequencer owning HI and LO.
// Optional macro DIV_ZERO_TRAP_EN: divide by zero skips the datapath and pulses div_zero.
module f_multdiv_seq (
  input  logic            clk,
  input  logic            reset,
  f_multdiv_seq_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StMult, StDiv, StFix, StDone} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        is_div_q, is_div_d;
  // Accumulator / remainder. The extra top bit keeps acc - (-2^31) from overflowing.
  logic [32:0] acc_q, acc_d;
  logic [31:0] mq_q, mq_d;
  logic        qm1_q, qm1_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
`ifdef DIV_ZERO_TRAP_EN
  logic        div_zero_q, div_zero_d;
`endif

  logic [32:0] booth_add;
  logic [32:0] booth_sum;
  logic [31:0] div_mag;
  logic [32:0] rem_sh;
  logic [32:0] rem_sub;
  logic        rem_ge;

  always_comb begin
    booth_add = {a_q[31], a_q};
    unique case ({mq_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + booth_add;
      2'b10:   booth_sum = acc_q - booth_add;
      default: booth_sum = acc_q;
    endcase

    div_mag = b_q[31] ? (~b_q + 32'd1) : b_q;
    rem_sh  = {acc_q[31:0], mq_q[31]};
    rem_ge  = (rem_sh >= {1'b0, div_mag});
    rem_sub = rem_sh - {1'b0, div_mag};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    qm1_d    = qm1_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
`ifdef DIV_ZERO_TRAP_EN
    div_zero_d = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.start_mult) begin
          a_d      = bus.op_a;
          b_d      = bus.op_b;
          is_div_d = 1'b0;
          cnt_d    = 6'd0;
          acc_d    = 33'd0;
          mq_d     = bus.op_b;
          qm1_d    = 1'b0;
          state_d  = StMult;
        end else if (bus.start_div) begin
          a_d      = bus.op_a;
          b_d      = bus.op_b;
          is_div_d = 1'b1;
          cnt_d    = 6'd0;
          acc_d    = 33'd0;
          mq_d     = bus.op_a[31] ? (~bus.op_a + 32'd1) : bus.op_a;
          qm1_d    = 1'b0;
          state_d  = StDiv;
`ifdef DIV_ZERO_TRAP_EN
          if (bus.op_b == 32'd0) begin
            state_d    = StDone;
            done_d     = 1'b1;
            div_zero_d = 1'b1;
          end
`endif
        end
      end

      StMult: begin
        acc_d = {booth_sum[32], booth_sum[32:1]};
        mq_d  = {booth_sum[0], mq_q[31:1]};
        qm1_d = mq_q[0];
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = StFix;
      end

      StDiv: begin
        acc_d = rem_ge ? rem_sub : rem_sh;
        mq_d  = {mq_q[30:0], rem_ge};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = StFix;
      end

      StFix: begin
        if (is_div_q) begin
          lo_d = (a_q[31] ^ b_q[31]) ? (~mq_q + 32'd1) : mq_q;
          hi_d = a_q[31] ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        end else begin
          hi_d = acc_q[31:0];
          lo_d = mq_q;
        end
        done_d  = 1'b1;
        state_d = StDone;
      end

      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= 6'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      is_div_q   <= 1'b0;
      acc_q      <= 33'd0;
      mq_q       <= 32'd0;
      qm1_q      <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
      div_zero_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      is_div_q   <= is_div_d;
      acc_q      <= acc_d;
      mq_q       <= mq_d;
      qm1_q      <= qm1_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef DIV_ZERO_TRAP_EN
      div_zero_q <= div_zero_d;
`endif
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;
`ifdef DIV_ZERO_TRAP_EN
  assign bus.div_zero = div_zero_q;
`else
  assign bus.div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_f_multdiv_seq.sv
// Randomized self-checking bench for f_multdiv_seq against a plain-arithmetic reference model.
module tb_f_multdiv_seq;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  f_multdiv_seq_if bus ();

  f_multdiv_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: signed 64-bit product.
  function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  // Reference model: truncating divide, remainder takes dividend sign; /0 gives the datapath result.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    if (b == 32'd0) begin
      q = a[31] ? 32'd1 : 32'hFFFF_FFFF;
      r = a;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end
  endfunction

  // Caller is at a falling edge (cycle 0); drives one start and follows the op to done+1.
  task automatic do_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                       input int poke_div, output int done_cyc, output logic busy_ok,
                       output logic dz, output logic [31:0] hi, output logic [31:0] lo,
                       output int n_done);
    bus.start_mult = m;
    bus.start_div  = d;
    bus.op_a       = a;
    bus.op_b       = b;
    done_cyc = -1;
    busy_ok  = 1'b1;
    dz       = 1'b0;
    hi       = 32'd0;
    lo       = 32'd0;
    n_done   = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      bus.start_mult = 1'b0;
      bus.start_div  = (k == poke_div);
      if (done_cyc < 0 && !bus.busy) busy_ok = 1'b0;
      if (bus.done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = k;
          dz = bus.div_zero;
          hi = bus.hi_out;
          lo = bus.lo_out;
        end
      end
      if (done_cyc >= 0 && k == done_cyc + 1) begin
        if (bus.busy) busy_ok = 1'b0;
        break;
      end
    end
    bus.start_div = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.busy, bus.done, bus.div_zero} !== 3'b000) begin
      $display("FAIL reset_flags: busy/done/div_zero=%b required 000",
               {bus.busy, bus.done, bus.div_zero});
      miscompares++;
    end
    vectors++;
    if ({bus.hi_out, bus.lo_out} !== 64'd0) begin
      $display("FAIL reset_hilo: hi=%h lo=%h required 0/0", bus.hi_out, bus.lo_out);
      miscompares++;
    end
    bus.start_mult = 1'b1;
    bus.op_a = 32'd3;
    bus.op_b = 32'd4;
    @(negedge clk);
    bus.start_mult = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0) begin
      $display("FAIL reset_start_ignored: busy=%b required 0", bus.busy);
      miscompares++;
    end
  endtask

  task automatic check_op(input string name, input int dc, input int exp_dc, input logic bok,
                          input logic dz, input logic exp_dz, input logic [31:0] hi,
                          input logic [31:0] exp_hi, input logic [31:0] lo,
                          input logic [31:0] exp_lo, input int nd);
    vectors++;
    if (dc !== exp_dc) begin
      $display("FAIL %s done_cycle: got %0d required %0d", name, dc, exp_dc);
      miscompares++;
    end
    vectors++;
    if (bok !== 1'b1 || nd !== 1) begin
      $display("FAIL %s busy/done_count: busy_ok=%b dones=%0d required 1/1", name, bok, nd);
      miscompares++;
    end
    vectors++;
    if (dz !== exp_dz) begin
      $display("FAIL %s div_zero: got %b required %b", name, dz, exp_dz);
      miscompares++;
    end
    vectors++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      $display("FAIL %s hi/lo: got %h/%h required %h/%h", name, hi, lo, exp_hi, exp_lo);
      miscompares++;
    end
  endtask

  task automatic test_mult();
    int dc, nd;
    logic bok, dz;
    logic [31:0] hi, lo, a, b;
    logic [63:0] p;
    do_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 0, dc, bok, dz, hi, lo, nd);
    check_op("mult_7x-3", dc, 34, bok, dz, 1'b0, hi, 32'hFFFF_FFFF, lo, 32'hFFFF_FFEB, nd);
    do_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 0, dc, bok, dz, hi, lo, nd);
    check_op("mult_min_sq", dc, 34, bok, dz, 1'b0, hi, 32'h4000_0000, lo, 32'h0, nd);
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 4 == 1) a = 32'h8000_0000;
      if (i % 4 == 2) b = 32'($signed($urandom_range(0, 20)) - 10);
      p = ref_mult(a, b);
      do_op(1'b1, 1'b0, a, b, 0, dc, bok, dz, hi, lo, nd);
      check_op("mult_rand", dc, 34, bok, dz, 1'b0, hi, p[63:32], lo, p[31:0], nd);
    end
  endtask

  task automatic test_div();
    int dc, nd;
    logic bok, dz;
    logic [31:0] hi, lo, a, b, q, r;
    do_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, dc, bok, dz, hi, lo, nd);
    check_op("div_-7/2", dc, 34, bok, dz, 1'b0, hi, 32'hFFFF_FFFF, lo, 32'hFFFF_FFFD, nd);
    do_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, dc, bok, dz, hi, lo, nd);
    check_op("div_min/-1", dc, 34, bok, dz, 1'b0, hi, 32'h0, lo, 32'h8000_0000, nd);
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 4 == 1) a = 32'h8000_0000;
      if (i % 4 == 2) b = 32'($signed($urandom_range(0, 40)) - 20);
      if (i % 4 == 3) b = b >> $urandom_range(0, 31);
      if (b == 32'd0) b = 32'd1;
      ref_div(a, b, q, r);
      do_op(1'b0, 1'b1, a, b, 0, dc, bok, dz, hi, lo, nd);
      check_op("div_rand", dc, 34, bok, dz, 1'b0, hi, r, lo, q, nd);
    end
  endtask

  task automatic test_div_zero();
    int dc, nd;
    logic bok, dz;
    logic [31:0] hi, lo, q, r;
    logic [31:0] vals [2];
    vals[0] = 32'd5;
    vals[1] = 32'hFFFF_FFF7;
    for (int i = 0; i < 2; i++) begin
      do_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 0, dc, bok, dz, hi, lo, nd);
      do_op(1'b0, 1'b1, vals[i], 32'd0, 0, dc, bok, dz, hi, lo, nd);
`ifdef DIV_ZERO_TRAP_EN
      check_op("div_zero_trap", dc, 1, bok, dz, 1'b1, hi, 32'hFFFF_FFFF, lo, 32'hFFFF_FFEB, nd);
      vectors++;
      if (bus.hi_out !== 32'hFFFF_FFFF || bus.lo_out !== 32'hFFFF_FFEB) begin
        $display("FAIL div_zero_hold: hi=%h lo=%h required ffffffff/ffffffeb",
                 bus.hi_out, bus.lo_out);
        miscompares++;
      end
`else
      ref_div(vals[i], 32'd0, q, r);
      check_op("div_zero_full", dc, 34, bok, dz, 1'b0, hi, r, lo, q, nd);
`endif
    end
  endtask

  task automatic test_priority_and_ignore();
    int dc, nd;
    logic bok, dz;
    logic [31:0] hi, lo;
    do_op(1'b1, 1'b1, 32'd6, 32'd3, 5, dc, bok, dz, hi, lo, nd);
    check_op("both_starts", dc, 34, bok, dz, 1'b0, hi, 32'd0, lo, 32'd18, nd);
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      $display("FAIL busy_start_not_queued: busy=%b done=%b required 0/0", bus.busy, bus.done);
      miscompares++;
    end
  endtask

  task automatic test_reset_midway();
    int dc, nd;
    logic bok, dz;
    logic [31:0] hi, lo;
    int early_done;
    early_done = 0;
    bus.start_mult = 1'b1;
    bus.op_a = 32'd1234;
    bus.op_b = 32'd5678;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      bus.start_mult = 1'b0;
      if (bus.done) early_done++;
      reset = (k == 10);
    end
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || early_done != 0) begin
      $display("FAIL reset_midway_flags: busy=%b done=%b early_dones=%0d required 0/0/0",
               bus.busy, bus.done, early_done);
      miscompares++;
    end
    vectors++;
    if (bus.hi_out !== 32'd0 || bus.lo_out !== 32'd0) begin
      $display("FAIL reset_midway_hilo: hi=%h lo=%h required 0/0", bus.hi_out, bus.lo_out);
      miscompares++;
    end
    // Start in absolute cycle 11; done expected at cycle 45, i.e. 34 cycles later.
    do_op(1'b1, 1'b0, 32'd1000, 32'hFFFF_FFFE, 0, dc, bok, dz, hi, lo, nd);
    check_op("after_reset", dc, 34, bok, dz, 1'b0, hi, 32'hFFFF_FFFF, lo, 32'hFFFF_F830, nd);
  endtask

  task automatic test_back_to_back();
    int dc, nd;
    logic bok, dz;
    logic [31:0] hi, lo, q, r;
    logic [63:0] p;
    p = ref_mult(32'h0001_2345, 32'hFFF0_0001);
    do_op(1'b1, 1'b0, 32'h0001_2345, 32'hFFF0_0001, 0, dc, bok, dz, hi, lo, nd);
    check_op("b2b_mult", dc, 34, bok, dz, 1'b0, hi, p[63:32], lo, p[31:0], nd);
    ref_div(32'h7FFF_FFFF, 32'hFFFF_FFF0, q, r);
    do_op(1'b0, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFF0, 0, dc, bok, dz, hi, lo, nd);
    check_op("b2b_div", dc, 34, bok, dz, 1'b0, hi, r, lo, q, nd);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.op_a = 32'd0;
    bus.op_b = 32'd0;
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_priority_and_ignore();
    test_reset_midway();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/f_multdiv_seq.md
# f_multdiv_seq

Multicycle sequencer for the signed MULT/DIV resource of the CPU datapath. Accepts a one-cycle start request from the control unit with operands taken from registers A and B. Runs a 32-iteration Booth multiply or restoring divide, owns the HI and LO registers feeding the register-write mux, and reports completion and divide-by-zero back to the control unit, which raises the DIV_ZERO exception.

## Interface
Parameters: none (width fixed at 32).
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; returns block to IDLE and clears HI/LO
- start_mult  input  1  request signed multiply; sampled only in IDLE
- start_div  input  1  request signed divide; sampled only in IDLE
- op_a  input  32  multiplicand / dividend (register A), latched on accept
- op_b  input  32  multiplier / divisor (register B), latched on accept
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse; HI/LO hold the new result while high
- div_zero  output  1  one-cycle pulse, coincident with done, on divide by zero (macro-dependent)
- hi_out  output  32  HI register (product high word / remainder)
- lo_out  output  32  LO register (product low word / quotient)

## Operation
- States: IDLE, MULT, DIV, FIX, DONE. Reset values: state IDLE, hi_out=0, lo_out=0, busy=0, done=0, div_zero=0, counter 0.
- IDLE: start_mult has priority over start_div when both are high. On accept, latch op_a/op_b and clear the 6-bit iteration counter.
  - Multiply goes to MULT.
  - Divide with op_b≠0 goes to DIV.
  - Divide with op_b=0 is handled per Configuration.
- MULT: radix-2 Booth on a 65-bit product register {acc[31:0], multiplier[31:0], q-1}. One add/sub-and-arithmetic-shift-right per cycle. After 32 iterations, go to FIX.
- DIV: restoring division on magnitudes |op_a|, |op_b|, one quotient bit per cycle. After 32 iterations, go to FIX.
- FIX: write HI/LO.
  - Multiply: HI=product[63:32], LO=product[31:0].
  - Divide: quotient negated if sign(a)≠sign(b); remainder negated if a<0. This gives truncation toward zero, with the remainder taking the sign of the dividend.
  - Go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Starts asserted outside IDLE are ignored (not queued).
- Arithmetic boundaries:
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. No flag.
  - |0x80000000| is taken as the unsigned 0x80000000. The 33-bit internal remainder prevents loss.
- HI/LO change only in FIX (or by reset). Otherwise they hold indefinitely.

## Timing
- Cycle 0 = cycle in which the start is high in IDLE (accepted at the end of cycle 0).
- MULT/DIV occupy cycles 1–32, FIX is cycle 33, DONE is cycle 34. busy is high in cycles 1–34. done and the new HI/LO are visible in cycle 34.
- Earliest next accept is cycle 35 (back in IDLE).
- Divide-by-zero path (macro on): DONE in cycle 1, done=div_zero=1 in cycle 1, busy high in cycle 1 only.
- Reset high during any state: at that edge go to IDLE, clear HI/LO, drop busy/done/div_zero. A start asserted together with reset is ignored.

## Configuration
- DIV_ZERO_TRAP_EN defined: divide with op_b=0 skips DIV/FIX and goes straight to DONE. div_zero pulses with done, and HI/LO stay unchanged.
- DIV_ZERO_TRAP_EN undefined: div_zero is tied 0 and the divide runs the full 34-cycle path.
  - Magnitude quotient is 0xFFFFFFFF with remainder |a|, then the sign fixup applies.
  - Final result: HI=op_a; LO=0xFFFFFFFF if op_a≥0, else LO=0x00000001.

## Test plan
- start_mult, op_a=7, op_b=0xFFFFFFFD (−3) -> busy in cycles 1–34; done in cycle 34 with HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- start_mult, op_a=op_b=0x80000000 -> HI=0x40000000, LO=0x00000000 at cycle 34.
- start_div, op_a=0xFFFFFFF9 (−7), op_b=2 -> LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1) at cycle 34. Then op_a=0x80000000, op_b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Preload HI/LO with a known result, then start_div with op_b=0, op_a=5:
  - Macro on: done=div_zero=1 in cycle 1, HI/LO unchanged.
  - Macro off: done in cycle 34, HI=5, LO=0xFFFFFFFF, div_zero=0.
- start_mult and start_div high together, op_a=6, op_b=3 -> multiply performed (LO=18, HI=0). start_div pulsed in cycle 5 while busy is ignored, and only one done is seen.
- Start a multiply, assert reset in cycle 10 -> cycle 11: busy=0, HI=LO=0, no done. A new start_mult accepted in cycle 11 completes with done in cycle 45.
